// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and state encoding for the nibble-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default word width, nibble width, FSM state type.
package nibble_serial_subtractor_pkg;

    localparam int WORD_WIDTH_DEFAULT = 32;
    localparam int NIBBLE_WIDTH       = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bundle between the control sequencer and the subtractor.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the subtractor is idle.
//
// Ports (master = sequencer, slave = subtractor):
//   start, a_in, b_in              master -> slave
//   busy, done, result, borrow_out slave -> master
//   negative, zero                 slave -> master, only with SUBTRACTOR_FLAGS_EN
interface nibble_serial_subtractor_if
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
);

    logic                  start;
    logic [WORD_WIDTH-1:0] a_in;
    logic [WORD_WIDTH-1:0] b_in;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] result;
    logic                  borrow_out;
`ifdef SUBTRACTOR_FLAGS_EN
    logic                  negative;
    logic                  zero;

    modport master (
        output start, a_in, b_in,
        input  busy, done, result, borrow_out, negative, zero
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, result, borrow_out, negative, zero
    );
`else
    modport master (
        output start, a_in, b_in,
        input  busy, done, result, borrow_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, result, borrow_out
    );
`endif

endinterface

// File: rtl/nibble_serial_subtractor_ttl283.sv
// 4-bit carry-lookahead adder slice (74x283 equivalent), purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
//
// Ports: a, b (4-bit addends), c0 (carry in) -> s (4-bit sum), c4 (carry out).
module ttl283_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    assign {c4, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c0};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Word subtractor A - B, one nibble per clock through a single 4-bit adder slice.
// Latency: done pulses NIBBLES edges after the accepted start edge; busy for NIBBLES cycles.
// Backpressure: start is ignored while busy or done; nothing is queued.
//
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// nibble_serial_subtractor_if: start/a_in/b_in in, busy/done/result/borrow_out out).
// Optional macro SUBTRACTOR_FLAGS_EN adds registered negative/zero flags.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
)(
    input  logic                           clk,
    input  logic                           reset,
    nibble_serial_subtractor_if.slave      bus
);

    localparam int NIBBLES = WORD_WIDTH / NIBBLE_WIDTH;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(NIBBLES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [WORD_WIDTH-1:0] a_sr;
    logic [WORD_WIDTH-1:0] b_sr;
    logic [WORD_WIDTH-1:0] result_sr;
    logic [WORD_WIDTH-1:0] result_q;
    logic                  carry_q;
    logic                  borrow_q;
    logic [CW-1:0]         count_q;

    logic [3:0]            slice_b;
    logic [3:0]            slice_sum;
    logic                  slice_c4;
    logic                  last_nibble;
    logic [WORD_WIDTH-1:0] result_next;

    // Subtraction as A + ~B + 1: the +1 is the carry preloaded at start.
    assign slice_b = ~b_sr[NIBBLE_WIDTH-1:0];

    ttl283_adder u_slice (
        .a  (a_sr[NIBBLE_WIDTH-1:0]),
        .b  (slice_b),
        .c0 (carry_q),
        .s  (slice_sum),
        .c4 (slice_c4)
    );

    // Sum nibbles enter at the top so that after NIBBLES shifts the first
    // (least-significant) nibble has walked down to bit 0.
    assign result_next = {slice_sum, result_sr[WORD_WIDTH-1:NIBBLE_WIDTH]};
    assign last_nibble = (count_q == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the published result only moves on the DONE-entry edge, so
    // partial sums in result_sr are never visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr      <= '0;
            b_sr      <= '0;
            result_sr <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a_in;
                        b_sr    <= bus.b_in;
                        carry_q <= 1'b1;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    a_sr      <= a_sr >> NIBBLE_WIDTH;
                    b_sr      <= b_sr >> NIBBLE_WIDTH;
                    result_sr <= result_next;
                    carry_q   <= slice_c4;
                    count_q   <= count_q + CW'(1);
                    if (last_nibble) begin
                        result_q <= result_next;
                        // No final carry means A + ~B + 1 did not overflow: A < B.
                        borrow_q <= ~slice_c4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.borrow_out = borrow_q;

`ifdef SUBTRACTOR_FLAGS_EN
    logic negative_q;
    logic zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (state_q == RUN && last_nibble) begin
            negative_q <= result_next[WORD_WIDTH-1];
            zero_q     <= (result_next == '0);
        end
    end

    assign bus.negative = negative_q;
    assign bus.zero     = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] exp_res_q;

    nibble_serial_subtractor_if #(.WORD_WIDTH(32)) bus ();

    nibble_serial_subtractor #(.WORD_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [31:0] exp);
`ifdef SUBTRACTOR_FLAGS_EN
        check({tag, ".negative"}, {31'b0, bus.negative}, {31'b0, exp[31]});
        check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, (exp == 32'd0)});
`else
        if (exp === 32'hxxxx_xxxx) $display("[TB] %s unknown expectation", tag);
`endif
    endtask

    // One operation; expectations come from plain unsigned arithmetic.
    // With scramble set, operands and start are randomised while the
    // operation is in flight to show they are neither captured nor queued.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input string tag);
        logic [31:0] exp_res;
        logic        exp_bor;
        int busy_cnt;
        int done_cnt;
        int done_at;
        exp_res  = a - b;
        exp_bor  = (a < b);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 4) check({tag, ".result_held"}, bus.result, exp_res_q);
            if (scramble) begin
                bus.a_in  = $urandom;
                bus.b_in  = $urandom;
                bus.start = (k <= 9) ? 1'($urandom_range(1)) : 1'b0;
            end
            if (k < 10) @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, ".busy_cycles"}, busy_cnt, 8);
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_at, 9);
        check({tag, ".idle_after"}, {31'b0, bus.busy}, 32'd0);
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".borrow"}, {31'b0, bus.borrow_out}, {31'b0, exp_bor});
        check_flags(tag, exp_res);
        exp_res_q = exp_res;
    endtask

    initial begin
        int prev_done;
        int dcount;
        int dn;
        tests     = 0;
        fails     = 0;
        exp_res_q = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", {31'b0, bus.busy}, 32'd0);
        check("rst.done", {31'b0, bus.done}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.borrow", {31'b0, bus.borrow_out}, 32'd0);
        check_flags("rst", 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("idle.busy", {31'b0, bus.busy}, 32'd0);

        do_op(32'd100, 32'd58, 1'b0, "sub_100_58");
        do_op(32'd5, 32'd7, 1'b0, "sub_5_7");
        do_op(32'd0, 32'd0, 1'b0, "sub_0_0");
        do_op(32'h8000_0000, 32'd1, 1'b0, "sub_wrap");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1, "sub_ignore_start");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i == 3) ? ra : $urandom;
            do_op(ra, rb, 1'($urandom_range(1)), $sformatf("rand%0d", i));
        end

        // Reset in the middle of an operation: no done must follow.
        @(negedge clk);
        bus.a_in  = 32'd20;
        bus.b_in  = 32'd10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.busy", {31'b0, bus.busy}, 32'd0);
        check("midrst.done", {31'b0, bus.done}, 32'd0);
        check("midrst.result", bus.result, 32'd0);
        check("midrst.borrow", {31'b0, bus.borrow_out}, 32'd0);
        check_flags("midrst", 32'd1);
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("midrst.no_done", dn, 0);
        exp_res_q = 32'd0;
        do_op(32'd20, 32'd10, 1'b0, "after_rst");

        // Start held high: one operation every NIBBLES+2 cycles.
        @(negedge clk);
        bus.a_in  = 32'd9;
        bus.b_in  = 32'd4;
        bus.start = 1'b1;
        prev_done = 0;
        dcount    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dcount++;
                check("b2b.result", bus.result, 32'd5);
                if (prev_done == 0) check("b2b.first_done", k, 9);
                else check("b2b.period", k - prev_done, 10);
                prev_done = k;
            end
        end
        bus.start = 1'b0;
        check("b2b.count", dcount, 4);
        repeat (12) @(negedge clk);
        check("b2b.idle", {31'b0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
